uart_rx_sampler: RTL and testbench

Oversampling UART receive front-end that turns the asynchronous serial input into framed bytes and stores them in a shift-type frame buffer. It sits directly downstream of the board pin and upstream of the display and LED logic, which read its `RXBUF` exactly as they read the transmit buffer. Bit timing is derived from a one-cycle oversample `tick` supplied by the baud-rate generator. Malformed frames are flagged and counted, never stored.

---
 rtl/uart_rx_sampler.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling UART receive front-end with a shift-type frame buffer.
//
// Ports:
//   clk        - system clock, all state on rising edge
//   reset      - asynchronous active-high reset
//   tick       - one-clk oversample enable at OVERSAMPLE x baud
//   RXserial   - raw serial line, idle high
//   RXBUF      - frame buffer, entry 0 newest; entry = {stop, start, data}
//   rx_valid   - one-clk pulse on frame push
//   frame_err  - one-clk pulse on rejected frame (stop bit sampled low)
//   overflow   - one-clk pulse when a push discards a valid oldest entry
//   fill       - valid entry count, saturating at DEPTH
//   err_count  - rejected frame count, saturating at 255
//   rx_busy    - high whenever the receiver is not idle
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   defined   -> each decision is a 2-of-3 vote over ticks mid-1, mid, mid+1,
//                taken at mid+1 (one tick later than the single-sample build)
//   undefined -> each decision uses the single sample at tick mid
module uart_rx_sampler #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned OVERSAMPLE = 16,
  localparam int unsigned FILL_W    = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          RXserial,
  output logic [DEPTH-1:0][WIDTH+1:0]   RXBUF,
  output logic                          rx_valid,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [FILL_W-1:0]             fill,
  output logic [7:0]                    err_count,
  output logic                          rx_busy
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE + 2);
  localparam int unsigned BIT_W = $clog2(WIDTH);
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned START_T = OVERSAMPLE / 2 + 1;
`else
  localparam int unsigned START_T = OVERSAMPLE / 2;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_next;
  logic               sync1, rxs;
  logic               armed, armed_next;
  logic [CNT_W-1:0]   cnt, cnt_next, cnt_inc, target;
  logic [BIT_W-1:0]   bit_idx, bit_next;
  logic [WIDTH-1:0]   shreg, shreg_next;
  logic               sample, decide, push_c, reject_c;

`ifdef UART_RX_MAJORITY_EN
  // Two early samples held for the vote; the third is the live line at decision time.
  logic maj_a, maj_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      maj_a <= 1'b1;
      maj_b <= 1'b1;
    end else if (tick && state != IDLE) begin
      if (cnt_inc == CNT_W'(target - CNT_W'(2))) maj_a <= rxs;
      if (cnt_inc == CNT_W'(target - CNT_W'(1))) maj_b <= rxs;
    end
  end

  assign sample = (maj_a & maj_b) | (maj_a & rxs) | (maj_b & rxs);
`else
  assign sample = rxs;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and decision logic; cnt counts ticks since detect or last decision
  always_comb begin
    state_next = state;
    armed_next = armed;
    cnt_next   = cnt;
    bit_next   = bit_idx;
    shreg_next = shreg;
    push_c     = 1'b0;
    reject_c   = 1'b0;
    cnt_inc    = cnt + CNT_W'(1);
    target     = (state == START) ? CNT_W'(START_T) : CNT_W'(OVERSAMPLE);
    decide     = tick && (cnt_inc == target);

    case (state)
      IDLE: begin
        if (tick) begin
          if (rxs) begin
            armed_next = 1'b1;
          end else if (armed) begin
            state_next = START;
            cnt_next   = '0;
            armed_next = 1'b0;
          end
        end
      end
      START: begin
        if (tick) cnt_next = cnt_inc;
        if (decide) begin
          cnt_next = '0;
          if (!sample) begin
            state_next = DATA;
            bit_next   = '0;
          end else begin
            state_next = IDLE;  // glitch: silent return
          end
        end
      end
      DATA: begin
        if (tick) cnt_next = cnt_inc;
        if (decide) begin
          cnt_next   = '0;
          shreg_next = {sample, shreg[WIDTH-1:1]};
          if (bit_idx == BIT_W'(WIDTH - 1)) state_next = STOP;
          else                              bit_next   = bit_idx + BIT_W'(1);
        end
      end
      STOP: begin
        if (tick) cnt_next = cnt_inc;
        if (decide) begin
          cnt_next   = '0;
          state_next = IDLE;  // leave at stop mid-point
          if (sample) push_c   = 1'b1;
          else        reject_c = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Synchronizer, datapath, frame buffer and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b1;
      rxs       <= 1'b1;
      armed     <= 1'b0;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      RXBUF     <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      fill      <= '0;
      err_count <= '0;
      rx_busy   <= 1'b0;
    end else begin
      sync1     <= RXserial;
      rxs       <= sync1;
      armed     <= armed_next;
      cnt       <= cnt_next;
      bit_idx   <= bit_next;
      shreg     <= shreg_next;
      rx_valid  <= push_c;
      frame_err <= reject_c;
      overflow  <= push_c && (fill == FILL_W'(DEPTH));
      rx_busy   <= (state_next != IDLE);
      if (push_c) begin
        for (int i = DEPTH - 1; i > 0; i--) RXBUF[i] <= RXBUF[i-1];
        RXBUF[0] <= {1'b1, 1'b0, shreg};
        if (fill != FILL_W'(DEPTH)) fill <= fill + FILL_W'(1);
      end
      if (reject_c && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: self-checking bench for uart_rx_sampler.
// Frames are driven at 16 ticks per bit with a tick every 4 clk; expected frames,
// errors and their decision ticks are queued at send time and retired by a
// monitor on the falling clock edge against a reference frame-buffer model.
`timescale 1ns/1ps
module tb_uart_rx_sampler;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned OS    = 16;
  // Ticks from the tick before the line drops to the stop decision tick.
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 1 + OS / 2 + OS * (WIDTH + 1) + 1;
`else
  localparam int LAT = 1 + OS / 2 + OS * (WIDTH + 1);
`endif

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic                        tick = 1'b0;
  logic                        RXserial = 1'b1;
  logic [DEPTH-1:0][WIDTH+1:0] RXBUF;
  logic                        rx_valid, frame_err, overflow, rx_busy;
  logic [2:0]                  fill;
  logic [7:0]                  err_count;

  uart_rx_sampler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OVERSAMPLE(OS)) dut (
    .clk(clk), .reset(reset), .tick(tick), .RXserial(RXserial),
    .RXBUF(RXBUF), .rx_valid(rx_valid), .frame_err(frame_err),
    .overflow(overflow), .fill(fill), .err_count(err_count), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  logic [1:0] div = 2'd0;
  int         tick_cnt = 0;
  always @(posedge clk) begin
    div  <= div + 2'd1;
    tick <= (div == 2'd3);
    if (tick) tick_cnt <= tick_cnt + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and reference model
  logic [WIDTH+1:0] q_frame[$];
  int               q_ftick[$];
  int               q_etick[$];
  logic [WIDTH+1:0] mbuf[DEPTH];
  int               mfill = 0;
  int               merr  = 0;
  int               n_valid = 0, n_err = 0, n_ovf = 0;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mbuf[i] = '0;
    mfill = 0;
    merr  = 0;
    q_frame.delete();
    q_ftick.delete();
    q_etick.delete();
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (overflow) n_ovf++;
      if (overflow && !rx_valid) check("overflow_without_push", overflow, 1'b0);
      if (rx_valid) begin
        n_valid++;
        if (q_frame.size() == 0) begin
          check("rx_valid_unexpected", rx_valid, 1'b0);
        end else begin
          logic [WIDTH+1:0] f;
          f = q_frame.pop_front();
          check("rx_valid_tick", tick_cnt, q_ftick.pop_front());
          check("overflow", overflow, (mfill == DEPTH));
          for (int i = DEPTH - 1; i > 0; i--) mbuf[i] = mbuf[i-1];
          mbuf[0] = f;
          if (mfill < DEPTH) mfill++;
        end
      end
      if (frame_err) begin
        n_err++;
        if (q_etick.size() == 0) check("frame_err_unexpected", frame_err, 1'b0);
        else                     check("frame_err_tick", tick_cnt, q_etick.pop_front());
        if (merr < 255) merr++;
      end
      if (rx_valid || frame_err) begin
        for (int i = 0; i < DEPTH; i++) check($sformatf("rxbuf%0d", i), RXBUF[i], mbuf[i]);
        check("fill", fill, mfill);
        check("err_count", err_count, merr);
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (tick !== 1'b1);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string pfx);
    for (int i = 0; i < DEPTH; i++) check($sformatf("%s_rxbuf%0d", pfx, i), RXBUF[i], 0);
    check({pfx, "_rx_valid"}, rx_valid, 0);
    check({pfx, "_frame_err"}, frame_err, 0);
    check({pfx, "_overflow"}, overflow, 0);
    check({pfx, "_fill"}, fill, 0);
    check({pfx, "_err_count"}, err_count, 0);
    check({pfx, "_rx_busy"}, rx_busy, 0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    RXserial = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_ticks(2);
  endtask

  // Drive one frame; abort_bit >= 0 asserts reset in the middle of that data bit.
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic spike,
                            input int abort_bit);
    logic [9:0] bits;
    int t0;
    bits = {stop, data, 1'b0};
    wait_ticks(1);
    t0 = tick_cnt;
    if (abort_bit < 0) begin
      if (stop) begin
        q_frame.push_back({1'b1, 1'b0, data});
        q_ftick.push_back(t0 + LAT);
      end else begin
        q_etick.push_back(t0 + LAT);
      end
    end
    for (int j = 0; j < 10; j++) begin
      RXserial = bits[j];
      if (abort_bit >= 0 && j == abort_bit + 1) begin
        wait_ticks(8);
        reset = 1'b1;
        model_clear();
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        RXserial = 1'b1;
        reset = 1'b0;
        return;
      end
      if (spike) begin
        wait_ticks(8);
        RXserial = ~bits[j];
        wait_ticks(1);
        RXserial = bits[j];
        wait_ticks(7);
      end else begin
        wait_ticks(16);
      end
    end
    RXserial = 1'b1;
    wait_ticks(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bv, be, bo, t0;
    model_clear();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    wait_ticks(2);

    // Single frame
    bv = n_valid; be = n_err;
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    check("single_rxbuf0", RXBUF[0], 10'b10_1010_0101);
    check("single_nvalid", n_valid - bv, 1);
    check("single_fill", fill, 1);
    check("single_err", err_count, 0);

    // Fill and overflow
    reset_dut();
    bv = n_valid; bo = n_ovf;
    for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1, 1'b0, -1);
    check("fill_buf3", RXBUF[3][7:0], 8'h02);
    check("fill_buf2", RXBUF[2][7:0], 8'h03);
    check("fill_buf1", RXBUF[1][7:0], 8'h04);
    check("fill_buf0", RXBUF[0][7:0], 8'h05);
    check("fill_count", fill, 4);
    check("fill_novf", n_ovf - bo, 1);
    check("fill_nvalid", n_valid - bv, 5);

    // Framing error, then recovery
    bv = n_valid; be = n_err;
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    check("ferr_nerr", n_err - be, 1);
    check("ferr_nvalid", n_valid - bv, 0);
    check("ferr_count", err_count, 1);
    check("ferr_fill", fill, 4);
    check("ferr_buf0", RXBUF[0][7:0], 8'h05);
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    check("ferr_recover_buf0", RXBUF[0], 10'h23C);

    // Glitch: 4-tick low pulse
    bv = n_valid; be = n_err; bo = n_ovf;
    wait_ticks(1);
    RXserial = 1'b0;
    wait_ticks(2);
    check("glitch_busy", rx_busy, 1);
    wait_ticks(2);
    RXserial = 1'b1;
    wait_ticks(8);
    check("glitch_idle", rx_busy, 0);
    check("glitch_pulses", (n_valid - bv) + (n_err - be) + (n_ovf - bo), 0);

    // Break: line low for 20 bit times
    bv = n_valid; be = n_err;
    wait_ticks(1);
    t0 = tick_cnt;
    RXserial = 1'b0;
    q_etick.push_back(t0 + LAT);
    wait_ticks(OS * 20);
    check("break_idle", rx_busy, 0);
    check("break_nerr", n_err - be, 1);
    check("break_nvalid", n_valid - bv, 0);
    RXserial = 1'b1;
    wait_ticks(OS);
    send_frame(8'h81, 1'b1, 1'b0, -1);
    check("break_recover_buf0", RXBUF[0], 10'h281);

    // Reset during data bit 3, then a clean frame
    send_frame(8'h7E, 1'b1, 1'b0, 3);
    wait_ticks(2);
    send_frame(8'h7E, 1'b1, 1'b0, -1);
    check("midreset_buf0", RXBUF[0], 10'h27E);
    check("midreset_fill", fill, 1);

`ifdef UART_RX_MAJORITY_EN
    // Majority vote rejects single-tick spikes at each mid-point
    send_frame(8'h55, 1'b1, 1'b1, -1);
    check("majority_buf0", RXBUF[0][7:0], 8'h55);
`endif

    check("sb_frames_left", q_frame.size(), 0);
    check("sb_errors_left", q_etick.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
